shift_req_sched: RTL and testbench
==================================

Name: shift_req_sched

Overview:
Shares one 8-bit constant-step shift datapath (SHL / SHR / ASHR, 0..7 bits per pass) among NREQ requesters. Arbitrates requests round-robin with valid/ready handshakes and sequences amounts above 7 as multiple passes. Returns each result with its requester id. Sits between requester blocks and the shared shifter in the arithmetic cluster.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width
AW, 4, shift-amount width (amount 0..2^AW-1)
PASS_MAX, 7, largest shift one datapath pass applies

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_op  input  2*NREQ  per-requester op: 0=SHL, 1=SHR, 2=ASHR, 3=NOP
req_data  input  DW*NREQ  per-requester operand; requester i uses slice [i*DW +: DW]
req_amt  input  AW*NREQ  per-requester shift amount
rsp_valid  output  1  result valid
rsp_ready  input  1  result accept
rsp_id  output  $clog2(NREQ)  index of the requester that owns the result
rsp_data  output  DW  shifted result
busy  output  1  high in the SHIFT and RESP states

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. req_ready is forced to 0 while rst_n is low.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - Grant goes to the first asserted req_valid, searching upward from the pointer with wrap-around.
  - req_ready[g] is asserted combinationally in IDLE only.
  - On handshake: latch op, data, amt and id=g into acc/rem/op_q/id_q; pointer <= (g+1) mod NREQ; go to SHIFT.
  - With no request valid, the pointer is unchanged.
- SHIFT: each cycle
  - step = min(rem, PASS_MAX);
  - acc <= acc shifted by step per op_q (SHL and SHR zero-fill, ASHR sign-fill, NOP unchanged);
  - rem <= rem - step;
  - go to RESP when rem - step == 0.
- Pass count and latency:
  - passes = max(1, ceil(amt/PASS_MAX)). Amount 0 still takes one pass.
  - rsp_valid rises exactly `passes` clock edges after the accepting edge.
- RESP:
  - rsp_valid=1, with rsp_data=acc and rsp_id=id_q held stable until rsp_ready.
  - On the handshake edge, go to IDLE and rsp_valid <= 0.
  - No new request is accepted in the same edge; minimum gap between accepts is passes+2 cycles.
- Amounts >= DW give 0 for SHL/SHR and all sign bits for ASHR. This falls out of the iterative passes and needs no special case.
- Requester inputs are sampled only at the handshake. Later changes have no effect.
- A requester that drops req_valid before a grant is never granted.
- Reset mid-operation: the transaction is discarded with no response; all state returns to reset values.
- rsp_valid, rsp_id and rsp_data are registered outputs.

Decomposition:
- Package shift_sched_pkg holds:
  - typedef enum logic [1:0] op_e {OP_SHL, OP_SHR, OP_ASHR, OP_NOP};
  - typedef enum state_e {IDLE, SHIFT, RESP};
  - localparam PASS_MAX.
- One sub-module, shift_rr_arb:
  - inputs NREQ req vector, pointer, enable;
  - outputs one-hot grant and encoded index;
  - purely combinational.
- The per-pass shifter is inline combinational logic in the FSM datapath.

Test Plan:
1. Req0 only: SHL, data 0x81, amt 1; rsp_ready=1 -> req_ready[0] for one cycle; rsp_valid one edge after accept; rsp_data=0x02, rsp_id=0; busy high from accept until the response handshake.
2. Multi-pass, three separate requests:
   - ASHR 0x80 amt 3 -> 0xF0, 1 pass;
   - SHR 0x40 amt 9 -> 0x00, rsp after 2 edges;
   - ASHR 0x90 amt 15 -> 0xFF, rsp after 3 edges (steps 7,7,1).
3. Zero and NOP: SHR 0xA5 amt 0 -> 0xA5 after 1 edge; op=3 data 0x3C amt 12 -> 0x3C after 2 edges.
4. Round-robin: all four req_valid held high with distinct data and rsp_ready=1 -> grant order 0,1,2,3,0; then drop req1 -> order 2,3,0,2.
5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready all 0; release -> IDLE next edge.
6. Reset during SHIFT of an amt=15 request (assert rst_n low between edges) -> outputs immediately at reset values, req_ready=0; after release, pointer=0 and no stale response appears.

Source files
------------

// File: rtl/shift_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sched_pkg
//  Description : Shared types and constants for the shared shift scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_sched_pkg;

  // Shift operation requested by a requester.
  typedef enum logic [1:0] {
    OP_SHL  = 2'd0,
    OP_SHR  = 2'd1,
    OP_ASHR = 2'd2,
    OP_NOP  = 2'd3
  } op_e;

  // Scheduler control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Largest shift a single datapath pass can apply.
  localparam int PASS_MAX = 7;

endpackage
`default_nettype wire

// File: rtl/shift_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rr_arb
//  Description : Combinational round-robin arbiter. Grants the first
//                asserted request at or above ptr, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   cand;
  logic          found;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (en && !found && req[cand[IW-1:0]]) begin
        grant[cand[IW-1:0]] = 1'b1;
        idx                 = cand[IW-1:0];
        found               = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : shift_req_sched
//  Description : Shares one constant-step shift datapath (0..PASS_MAX bits
//                per pass) among NREQ requesters. Round-robin arbitration,
//                multi-pass sequencing of large amounts, result tagged with
//                the owning requester id.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_req_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int PASS_MAX = shift_sched_pkg::PASS_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [DW*NREQ-1:0]      req_data,
  input  logic [AW*NREQ-1:0]      req_amt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           rsp_data,
  output logic                    busy
);

  import shift_sched_pkg::*;

  localparam int IW = $clog2(NREQ);

  state_e          state;
  state_e          state_nx;

  logic [1:0]      op_arr   [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [AW-1:0]   amt_arr  [NREQ];

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            accept;

  logic [IW-1:0]   ptr;
  logic [DW-1:0]   acc;
  logic [AW-1:0]   rem;
  op_e             op_q;
  logic [IW-1:0]   id_q;
  logic            rsp_valid_q;

  logic [AW-1:0]   step;
  logic [AW-1:0]   rem_nx;
  logic [DW-1:0]   acc_nx;
  logic            last_pass;

  // Split the flat requester buses into per-requester fields.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]   = req_op[2*i +: 2];
    assign data_arr[i] = req_data[DW*i +: DW];
    assign amt_arr[i]  = req_amt[AW*i +: AW];
  end

  shift_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (grant),
    .idx   (gidx)
  );

  // Grants are only visible in IDLE; forced low while reset is asserted.
  assign req_ready = rst_n ? grant : '0;
  assign accept    = |grant;

  // One datapath pass: clip the remaining amount and shift per the latched op.
  always_comb begin
    step      = (rem > AW'(PASS_MAX)) ? AW'(PASS_MAX) : rem;
    rem_nx    = rem - step;
    last_pass = (rem_nx == '0);
    case (op_q)
      OP_SHL:  acc_nx = acc << step;
      OP_SHR:  acc_nx = acc >> step;
      OP_ASHR: acc_nx = $signed(acc) >>> step;
      default: acc_nx = acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and status output.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_pass) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        busy = 1'b1;
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch the granted request, iterate passes, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      acc         <= '0;
      rem         <= '0;
      op_q        <= OP_SHL;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= data_arr[gidx];
            rem  <= amt_arr[gidx];
            op_q <= op_e'(op_arr[gidx]);
            id_q <= gidx;
            ptr  <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          rem <= rem_nx;
          if (last_pass) begin
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = acc;
  assign rsp_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_req_sched
//  Description : Scoreboard bench for shift_req_sched with a behavioural
//                reference model of arbitration, shift results and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_req_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 4;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op    = '0;
  logic [DW*NREQ-1:0]    req_data  = '0;
  logic [AW*NREQ-1:0]    req_amt   = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [DW-1:0]         rsp_data;
  logic                  busy;

  typedef struct {
    int id;
    int data;
    int acc_edge;
    int passes;
  } exp_t;

  exp_t sbq[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   mptr     = 0;
  bit   mbusy    = 1'b0;
  bit   mon_prev = 1'b0;
  int   f_op   [NREQ];
  int   f_data [NREQ];
  int   f_amt  [NREQ];

  shift_req_sched #(
    .NREQ (NREQ),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference result: whole shift applied at once on plain integers.
  function automatic int ref_shift(input int op, input int d, input int amt);
    int sv;
    case (op)
      0:       return (d << amt) & 255;
      1:       return d >> amt;
      2: begin
        sv = (d >= 128) ? d - 256 : d;
        return (sv >>> amt) & 255;
      end
      default: return d;
    endcase
  endfunction

  function automatic int ref_passes(input int amt);
    return (amt == 0) ? 1 : (amt + 6) / 7;
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      f_op[i]   = int'($urandom_range(0, 3));
      f_data[i] = int'($urandom_range(0, 255));
      f_amt[i]  = int'($urandom_range(0, 15));
    end
  endtask

  // One cycle of stimulus; predicts grant and pushes the expected response.
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int g;
    @(posedge clk);
    #1;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]    = f_op[i][1:0];
      req_data[DW*i +: DW] = f_data[i][7:0];
      req_amt[AW*i +: AW]  = f_amt[i][3:0];
    end
    #3;
    chk("busy", {31'd0, busy}, {31'd0, mbusy});
    g = mbusy ? -1 : ref_grant(v);
    chk("req_ready", {28'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      sbq.push_back('{g, ref_shift(f_op[g], f_data[g], f_amt[g]), cyc + 1, ref_passes(f_amt[g])});
      mptr  = (g + 1) % NREQ;
      mbusy = 1'b1;
    end
  endtask

  task automatic wait_idle(input logic rr);
    int n = 0;
    while (mbusy && n < 60) begin
      step('0, rr);
      n++;
    end
    if (mbusy) timeout_fail("wait_idle");
  endtask

  task automatic issue_one(input int idx, input int op, input int d, input int amt);
    int n = 0;
    f_op[idx]   = op;
    f_data[idx] = d;
    f_amt[idx]  = amt;
    while (!mbusy && n < 20) begin
      step(NREQ'(1 << idx), 1'b1);
      n++;
    end
    if (!mbusy) timeout_fail("accept");
    wait_idle(1'b1);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    forever begin
      @(posedge clk);
      #6;
      if (!rst_n) begin
        mon_prev = 1'b0;
      end else begin
        if (rsp_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data %0h expected no response (cycle %0d)",
                     rsp_id, rsp_data, cyc);
          end else begin
            if (!mon_prev) chk("latency", cyc, sbq[0].acc_edge + sbq[0].passes);
            chk("rsp_id", {30'd0, rsp_id}, sbq[0].id);
            chk("rsp_data", {24'd0, rsp_data}, sbq[0].data);
            if (rsp_ready) begin
              void'(sbq.pop_front());
              mbusy = 1'b0;
            end
          end
        end
        mon_prev = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin
      f_op[i] = 0; f_data[i] = 0; f_amt[i] = 0;
    end

    // Reset values, with requests pending to prove req_ready is forced low.
    req_valid = '1;
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single requests, including multi-pass, zero and NOP.
    issue_one(0, 0, 8'h81, 1);
    issue_one(1, 2, 8'h80, 3);
    issue_one(2, 1, 8'h40, 9);
    issue_one(3, 2, 8'h90, 15);
    issue_one(0, 1, 8'hA5, 0);
    issue_one(1, 3, 8'h3C, 12);

    // Round-robin with all requesters, then with requester 1 dropped.
    for (int i = 0; i < NREQ; i++) begin
      f_op[i] = 0; f_data[i] = 16 * (i + 1); f_amt[i] = 1;
    end
    for (int i = 0; i < 16; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < 16; i++) step(4'b1101, 1'b1);
    wait_idle(1'b1);

    // Backpressure: hold the response for several cycles.
    n = 0;
    while (!mbusy && n < 20) begin
      step(4'b0100, 1'b0);
      n++;
    end
    for (int i = 0; i < 8; i++) step('0, 1'b0);
    wait_idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      rand_fields();
      step(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
    end
    wait_idle(1'b1);

    // Reset in the middle of a long multi-pass operation.
    f_op[1] = 2; f_data[1] = 8'h90; f_amt[1] = 15;
    n = 0;
    while (!mbusy && n < 20) begin
      step(4'b0010, 1'b1);
      n++;
    end
    step('0, 1'b1);
    @(posedge clk);
    #1 req_valid = '1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_req_ready", {28'd0, req_ready}, 0);
    chk("mid_rst_rsp_id", {30'd0, rsp_id}, 0);
    chk("mid_rst_rsp_data", {24'd0, rsp_data}, 0);
    req_valid = '0;
    sbq.delete();
    mbusy = 1'b0;
    mptr  = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step('0, 1'b1);
    // Pointer back at zero: requester 1 wins over 3.
    rand_fields();
    step(4'b1010, 1'b1);
    wait_idle(1'b1);

    for (int i = 0; i < 4; i++) step('0, 1'b1);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
